vx_mem_responder: RTL and testbench



---
 rtl/vx_mem_responder.sv | 163 ++++++++++++++++
 tb/tb_vx_mem_responder.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_mem_responder.sv
// vx_mem_responder: memory-side target for the valid/ready memory interface.
// Byte-enabled RAM, fixed-latency response pipeline, and an in-order response
// FIFO. A credit counter guarantees that every response entering the pipeline
// has a FIFO slot waiting, so the pipeline never stalls.
// Build option VX_MEM_RESPONDER_WACK_EN: writes also return an ack (echoed
// tag, data 0) through the same pipeline, and writes then consume a credit.
module vx_mem_responder #(
    parameter int DATA_WIDTH     = 512,
    parameter int ADDR_WIDTH     = 10,
    parameter int TAG_WIDTH      = 8,
    parameter int LATENCY        = 2,
    parameter int RSP_QUEUE_SIZE = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mem_req_valid,
    input  logic [ADDR_WIDTH-1:0]   mem_req_addr,
    input  logic                    mem_req_rw,
    input  logic [DATA_WIDTH/8-1:0] mem_req_byteen,
    input  logic [DATA_WIDTH-1:0]   mem_req_data,
    input  logic [TAG_WIDTH-1:0]    mem_req_tag,
    output logic                    mem_req_ready,
    output logic                    mem_rsp_valid,
    output logic [DATA_WIDTH-1:0]   mem_rsp_data,
    output logic [TAG_WIDTH-1:0]    mem_rsp_tag,
    input  logic                    mem_rsp_ready
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int PTR_W = $clog2(RSP_QUEUE_SIZE);
    localparam int PW    = PTR_W + 1;
    localparam int CRD_W = $clog2(RSP_QUEUE_SIZE + 1);

    logic [DATA_WIDTH-1:0] ram_q [DEPTH];
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic [DATA_WIDTH-1:0] ram_wdata_d;
    logic [DATA_WIDTH-1:0] stage_data;

    logic                  req_fire;
    logic                  rsp_gen;
    logic                  rsp_fire;
    logic [CRD_W-1:0]      credits_q, credits_d;

    logic                  push_vld;
    logic [TAG_WIDTH-1:0]  push_tag;
    logic [DATA_WIDTH-1:0] push_data;

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] fifo_data_q [RSP_QUEUE_SIZE];
    logic [TAG_WIDTH-1:0]  fifo_tag_q  [RSP_QUEUE_SIZE];
    logic                  fifo_empty;
    logic                  fifo_full;

`ifdef VX_MEM_RESPONDER_WACK_EN
    // Every request produces a response, so every request needs a credit.
    assign mem_req_ready = (credits_q != '0);
    assign rsp_gen       = req_fire;
`else
    // Writes are silent and bypass the credit check.
    assign mem_req_ready = mem_req_rw | (credits_q != '0);
    assign rsp_gen       = req_fire & ~mem_req_rw;
`endif

    assign req_fire   = mem_req_valid & mem_req_ready;
    assign rsp_fire   = mem_rsp_valid & mem_rsp_ready;
    assign ram_rdata  = ram_q[mem_req_addr];
    // Write acks carry zero data; reads carry the RAM word as of this cycle.
    assign stage_data = mem_req_rw ? '0 : ram_rdata;

    // Merge enabled write bytes over the current word.
    always_comb begin
        ram_wdata_d = ram_rdata;
        for (int i = 0; i < BE_W; i++) begin
            if (mem_req_byteen[i]) ram_wdata_d[i*8 +: 8] = mem_req_data[i*8 +: 8];
        end
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (req_fire && mem_req_rw) ram_q[mem_req_addr] <= ram_wdata_d;
    end

    // Response pipeline: stage 0 is the firing request itself, so LATENCY-1
    // register stages plus the FIFO register give exactly LATENCY cycles.
    generate
        if (LATENCY == 1) begin : g_lat1
            assign push_vld  = rsp_gen;
            assign push_tag  = mem_req_tag;
            assign push_data = stage_data;
        end else begin : g_pipe
            localparam int STAGES = LATENCY - 1;
            logic [STAGES-1:0]                 vld_pipe_q, vld_pipe_d;
            logic [STAGES-1:0][TAG_WIDTH-1:0]  tag_pipe_q, tag_pipe_d;
            logic [STAGES-1:0][DATA_WIDTH-1:0] data_pipe_q, data_pipe_d;

            // Shift the pipeline one stage per cycle; it never stalls.
            always_comb begin
                vld_pipe_d     = vld_pipe_q << 1;
                tag_pipe_d     = tag_pipe_q << TAG_WIDTH;
                data_pipe_d    = data_pipe_q << DATA_WIDTH;
                vld_pipe_d[0]  = rsp_gen;
                tag_pipe_d[0]  = mem_req_tag;
                data_pipe_d[0] = stage_data;
            end

            // Only the valid bits are reset; payload follows valid.
            always_ff @(posedge clk) begin
                if (reset) vld_pipe_q <= '0;
                else       vld_pipe_q <= vld_pipe_d;
                tag_pipe_q  <= tag_pipe_d;
                data_pipe_q <= data_pipe_d;
            end

            assign push_vld  = vld_pipe_q[STAGES-1];
            assign push_tag  = tag_pipe_q[STAGES-1];
            assign push_data = data_pipe_q[STAGES-1];
        end
    endgenerate

    // FIFO status from wrap-bit pointers.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    assign mem_rsp_valid = ~fifo_empty;
    assign mem_rsp_data  = fifo_data_q[rd_ptr_q[PTR_W-1:0]];
    assign mem_rsp_tag   = fifo_tag_q[rd_ptr_q[PTR_W-1:0]];

    // Next pointer and credit values.
    always_comb begin
        wr_ptr_d  = wr_ptr_q + (push_vld ? PW'(1) : PW'(0));
        rd_ptr_d  = rd_ptr_q + (rsp_fire ? PW'(1) : PW'(0));
        credits_d = credits_q;
        if (rsp_gen && !rsp_fire)      credits_d = credits_q - CRD_W'(1);
        else if (!rsp_gen && rsp_fire) credits_d = credits_q + CRD_W'(1);
    end

    // Control state; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            credits_q <= CRD_W'(RSP_QUEUE_SIZE);
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            credits_q <= credits_d;
        end
    end

    // FIFO storage write; a push on a full FIFO is only legal with a pop.
    always_ff @(posedge clk) begin
        if (push_vld) begin
            fifo_data_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
            fifo_tag_q[wr_ptr_q[PTR_W-1:0]]  <= push_tag;
        end
        if (!reset) begin
            assert (!(push_vld && fifo_full && !rsp_fire));
        end
    end

endmodule

// File: tb/tb_vx_mem_responder.sv
// Self-checking bench for vx_mem_responder: directed table, multi-cycle
// corner sequences, and randomized traffic against a transaction-level model.
module tb_vx_mem_responder;
    localparam int DW  = 512;
    localparam int AW  = 10;
    localparam int TW  = 8;
    localparam int LAT = 2;
    localparam int QS  = 4;
    localparam int BW  = DW / 8;
    localparam logic [BW-1:0] BE_ALL = '1;

    logic          clk = 1'b0;
    logic          reset;
    logic          mem_req_valid;
    logic [AW-1:0] mem_req_addr;
    logic          mem_req_rw;
    logic [BW-1:0] mem_req_byteen;
    logic [DW-1:0] mem_req_data;
    logic [TW-1:0] mem_req_tag;
    logic          mem_req_ready;
    logic          mem_rsp_valid;
    logic [DW-1:0] mem_rsp_data;
    logic [TW-1:0] mem_rsp_tag;
    logic          mem_rsp_ready;

    always #5 clk = ~clk;

    vx_mem_responder #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW),
        .LATENCY(LAT), .RSP_QUEUE_SIZE(QS)
    ) dut (
        .clk(clk), .reset(reset),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_req_rw(mem_req_rw), .mem_req_byteen(mem_req_byteen),
        .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
        .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .mem_rsp_tag(mem_rsp_tag), .mem_rsp_ready(mem_rsp_ready)
    );

    typedef struct { logic [TW-1:0] tag; logic [DW-1:0] data; int fire; } exp_t;
    typedef struct { logic [TW-1:0] tag; logic [DW-1:0] data; int lat; } pop_t;
    typedef struct {
        bit rw; int addr; logic [BW-1:0] be; logic [7:0] fill; logic [TW-1:0] tag;
        logic [7:0] exp_b0; logic [7:0] exp_rest;
    } vec_t;

    exp_t          exp_q[$];
    pop_t          pops_q[$];
    logic [DW-1:0] model_mem [int];
    int            cyc;
    int            errors;
    int            checks;
    bit            fired;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic model_write(input int a, input logic [BW-1:0] be, input logic [DW-1:0] d);
        logic [DW-1:0] w;
        w = model_mem.exists(a) ? model_mem[a] : '0;
        for (int i = 0; i < BW; i++) if (be[i]) w[i*8 +: 8] = d[i*8 +: 8];
        model_mem[a] = w;
    endtask

    // One clock: compare against the model at negedge, advance the model,
    // then let inputs change 1 time unit after the rising edge.
    task automatic step();
        bit exp_v;
        bit exp_rdy;
        exp_t e;
        pop_t p;
        @(negedge clk);
        exp_v = (exp_q.size() != 0) && (cyc >= exp_q[0].fire + LAT);
`ifdef VX_MEM_RESPONDER_WACK_EN
        exp_rdy = (exp_q.size() < QS);
`else
        exp_rdy = mem_req_rw || (exp_q.size() < QS);
`endif
        chk("rsp_valid", DW'(mem_rsp_valid), DW'(exp_v));
        if (mem_req_valid && !reset) chk("req_ready", DW'(mem_req_ready), DW'(exp_rdy));
        fired = 1'b0;
        if (exp_v && mem_rsp_valid) begin
            chk("rsp_tag", DW'(mem_rsp_tag), DW'(exp_q[0].tag));
            chk("rsp_data", mem_rsp_data, exp_q[0].data);
            if (mem_rsp_ready && !reset) begin
                p.tag = mem_rsp_tag; p.data = mem_rsp_data; p.lat = cyc - exp_q[0].fire;
                pops_q.push_back(p);
                void'(exp_q.pop_front());
            end
        end
        if (mem_req_valid && mem_req_ready && !reset) begin
            fired = 1'b1;
            e.tag = mem_req_tag; e.fire = cyc;
            if (mem_req_rw) begin
                model_write(int'(mem_req_addr), mem_req_byteen, mem_req_data);
`ifdef VX_MEM_RESPONDER_WACK_EN
                e.data = '0;
                exp_q.push_back(e);
`endif
            end else begin
                e.data = model_mem.exists(int'(mem_req_addr)) ? model_mem[int'(mem_req_addr)] : '0;
                exp_q.push_back(e);
            end
        end
        if (reset) exp_q.delete();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic issue(input bit rw, input int a, input logic [BW-1:0] be,
                         input logic [DW-1:0] d, input logic [TW-1:0] t);
        mem_req_valid = 1'b1; mem_req_rw = rw; mem_req_addr = AW'(a);
        mem_req_byteen = be; mem_req_data = d; mem_req_tag = t;
        for (int n = 0; n < 50; n++) begin
            step();
            if (fired) break;
        end
        checks++;
        if (!fired) begin
            errors++;
            $display("FAIL issue_timeout: tag %0h not accepted within 50 cycles", t);
        end
        mem_req_valid = 1'b0;
    endtask

    task automatic wait_tag(input logic [TW-1:0] t, input string name, output pop_t p);
        bit found;
        found = 1'b0;
        p.tag = '0; p.data = '0; p.lat = 0;
        for (int n = 0; n < 50 && !found; n++) begin
            foreach (pops_q[i]) if (!found && pops_q[i].tag == t) begin p = pops_q[i]; found = 1'b1; end
            if (!found) step();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s: no response for tag %0h within 50 cycles", name, t);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          tbl[13];
        pop_t          p;
        logic [DW-1:0] expd;
        int            nf;
        bit            blocked;

        errors = 0; checks = 0; cyc = 0; fired = 1'b0;
        reset = 1'b1; mem_req_valid = 1'b0; mem_req_rw = 1'b0; mem_req_addr = '0;
        mem_req_byteen = '0; mem_req_data = '0; mem_req_tag = '0; mem_rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        chk("reset_rsp_valid", DW'(mem_rsp_valid), '0);
        chk("reset_req_ready", DW'(mem_req_ready), DW'(1));
        step(); step();

        // Directed table: {rw, addr, byteen, fill, tag, expected byte0, expected other bytes}
        tbl[0]  = '{1'b1, 5,    BE_ALL,     8'hA5, 8'h01, 8'h00, 8'h00};
        tbl[1]  = '{1'b0, 5,    '0,         8'h00, 8'h11, 8'hA5, 8'hA5};
        tbl[2]  = '{1'b1, 5,    BW'(1),     8'h3C, 8'h02, 8'h00, 8'h00};
        tbl[3]  = '{1'b0, 5,    '0,         8'h00, 8'h12, 8'h3C, 8'hA5};
        tbl[4]  = '{1'b1, 7,    BE_ALL,     8'h5A, 8'h03, 8'h00, 8'h00};
        tbl[5]  = '{1'b0, 7,    '0,         8'h00, 8'h13, 8'h5A, 8'h5A};
        tbl[6]  = '{1'b1, 7,    ~BW'(1),    8'h66, 8'h04, 8'h00, 8'h00};
        tbl[7]  = '{1'b0, 7,    '0,         8'h00, 8'h14, 8'h5A, 8'h66};
        tbl[8]  = '{1'b1, 1023, BE_ALL,     8'hC3, 8'h05, 8'h00, 8'h00};
        tbl[9]  = '{1'b0, 1023, '0,         8'h00, 8'h15, 8'hC3, 8'hC3};
        tbl[10] = '{1'b1, 0,    BE_ALL,     8'h0F, 8'h06, 8'h00, 8'h00};
        tbl[11] = '{1'b1, 0,    '0,         8'hFF, 8'h07, 8'h00, 8'h00};
        tbl[12] = '{1'b0, 0,    '0,         8'h00, 8'h16, 8'h0F, 8'h0F};
        pops_q.delete();
        for (int i = 0; i < 13; i++) begin
            issue(tbl[i].rw, tbl[i].addr, tbl[i].be, {BW{tbl[i].fill}}, tbl[i].tag);
            if (!tbl[i].rw) begin
                wait_tag(tbl[i].tag, $sformatf("tbl%0d_rsp", i), p);
                expd = {BW{tbl[i].exp_rest}};
                expd[7:0] = tbl[i].exp_b0;
                chk($sformatf("tbl%0d_data", i), p.data, expd);
                chk($sformatf("tbl%0d_latency", i), DW'(p.lat), DW'(LAT));
            end
        end

`ifdef VX_MEM_RESPONDER_WACK_EN
        // Write ack: echoed tag with zero data
        pops_q.delete();
        issue(1'b1, 9, BE_ALL, rand_word(), 8'h22);
        wait_tag(8'h22, "wack_rsp", p);
        chk("wack_data", p.data, '0);
        chk("wack_latency", DW'(p.lat), DW'(LAT));
`endif

        // Credit exhaustion with the response side stalled
        mem_rsp_ready = 1'b0;
        pops_q.delete();
        for (int k = 0; k < QS; k++) issue(1'b0, 5, '0, '0, TW'(8'h30 + k));
        mem_req_valid = 1'b1; mem_req_rw = 1'b0; mem_req_addr = AW'(5); mem_req_tag = 8'h34;
        blocked = 1'b1;
        for (int n = 0; n < 4; n++) begin
            step();
            if (fired) blocked = 1'b0;
        end
        chk("fifth_read_blocked", DW'(blocked), DW'(1));
        mem_rsp_ready = 1'b1;
        for (int n = 0; n < 20 && !fired; n++) step();
        chk("fifth_read_accepted", DW'(fired), DW'(1));
        mem_req_valid = 1'b0;
        wait_tag(8'h34, "fifth_rsp", p);
        chk("stall_pop_count", DW'(pops_q.size()), DW'(5));
        for (int k = 0; k < 5 && k < pops_q.size(); k++)
            chk($sformatf("stall_order%0d", k), DW'(pops_q[k].tag), DW'(8'h30 + k));

        // Back-to-back reads with the response side always ready
        step(); step();
        pops_q.delete();
        nf = 0;
        for (int n = 0; n < 20; n++) begin
            mem_req_valid = 1'b1; mem_req_rw = 1'b0; mem_req_addr = AW'(7);
            mem_req_tag = TW'(8'h40 + n);
            step();
            if (fired) nf++;
        end
        mem_req_valid = 1'b0;
        chk("stream_accepts", DW'(nf), DW'(20));
        chk("stream_pops_in_window", DW'(pops_q.size()), DW'(20 - LAT));
        for (int n = 0; n < 2 * LAT; n++) step();
        chk("stream_pops_total", DW'(pops_q.size()), DW'(20));

        // Reset with reads outstanding
        mem_rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) issue(1'b0, 5, '0, '0, TW'(8'h50 + k));
        reset = 1'b1;
        step();
        reset = 1'b0;
        mem_req_rw = 1'b0;
        chk("post_reset_rsp_valid", DW'(mem_rsp_valid), '0);
        chk("post_reset_req_ready", DW'(mem_req_ready), DW'(1));
        mem_rsp_ready = 1'b1;
        pops_q.delete();
        for (int n = 0; n < 8; n++) step();
        chk("post_reset_no_stale", DW'(pops_q.size()), '0);
        issue(1'b0, 7, '0, '0, 8'h55);
        wait_tag(8'h55, "post_reset_rsp", p);
        expd = {BW{8'h66}};
        expd[7:0] = 8'h5A;
        chk("post_reset_data_persist", p.data, expd);

        // Randomized traffic over a small pre-written address window
        for (int a = 0; a < 16; a++) issue(1'b1, a, BE_ALL, rand_word(), TW'(8'h60 + a));
        fired = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if (!mem_req_valid || fired) begin
                if ($urandom_range(99) < 70) begin
                    mem_req_valid  = 1'b1;
                    mem_req_rw     = ($urandom_range(99) < 30);
                    mem_req_addr   = AW'($urandom_range(15));
                    mem_req_byteen = {$urandom, $urandom};
                    mem_req_data   = rand_word();
                    mem_req_tag    = TW'($urandom);
                end else begin
                    mem_req_valid = 1'b0;
                end
            end
            mem_rsp_ready = ($urandom_range(99) < 70);
            step();
        end
        mem_req_valid = 1'b0;
        mem_rsp_ready = 1'b1;
        for (int n = 0; n < 20; n++) step();
        chk("random_drained", DW'(exp_q.size()), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
